axis_stream_checker: RTL and testbench

- Downstream sink for the AXI-stream FIFO read side (readData/readDataValid/readDataReady/readDataLast).
- Drives ready with a programmable backpressure pattern.
- Checks each packet against the incrementing-count format produced by the upstream counter source: data starts at 0 in every packet and increments by 1 per beat; last is asserted on beat expected_len-1.
- Counts good packets and errors for bench and on-board status.

---
 rtl/axis_stream_pkg.sv | 15 +
 rtl/axis_sat_counter.sv | 24 ++
 rtl/axis_stream_checker.sv | 125 ++++++++++++
 tb/tb_axis_stream_checker.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stream_pkg.sv
// Shared types and helpers for the AXI-stream packet checker.
package axis_stream_pkg;

   typedef enum logic [1:0] {IDLE, RECV, HALT} chk_state_t;

   localparam int MASK_W = 8;

   // Increments v, holding at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] lim;
      lim = (64'd1 << w) - 64'd1;
      return (v >= lim) ? lim : v + 64'd1;
   endfunction

endpackage

// File: rtl/axis_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module axis_sat_counter
   import axis_stream_pkg::*;
#(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             inc,
   output logic [Width-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= Width'(sat_inc(64'(count), Width));
      end
   end

endmodule

// File: rtl/axis_stream_checker.sv
// Stream sink that applies rotating backpressure and checks incrementing-count packets.
// Optional beat/stall statistics are enabled with AXIS_STREAM_CHECKER_STATS_EN.
module axis_stream_checker
   import axis_stream_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned CntWidth  = 16,
   parameter bit          StopOnErr = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [DataWidth-1:0] expected_len,
   input  logic [MASK_W-1:0]    ready_mask,
   input  logic [DataWidth-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_last,
   output logic [CntWidth-1:0]  pkt_count,
   output logic [CntWidth-1:0]  err_count,
   output logic                 data_err,
   output logic                 len_err,
   output logic                 pkt_done,
   output logic                 busy
`ifdef AXIS_STREAM_CHECKER_STATS_EN
   ,
   output logic [CntWidth-1:0]  beat_count,
   output logic [CntWidth-1:0]  stall_count
`endif
);

   chk_state_t           state, stateNext;
   logic [2:0]           maskIdx;
   logic [DataWidth-1:0] lenQ;
   logic [DataWidth-1:0] beatIdx;
   logic                 pktBad;
   logic                 accept, beat, dataMis, lenMis, anyErr, pktGood;

   assign s_ready = (state == RECV) & ready_mask[maskIdx];
   assign busy    = (state == RECV);
   assign accept  = s_valid & s_ready;
   // A beat coinciding with clear is dropped from checking.
   assign beat    = accept & ~clear;

   // The expected data word always equals the beat index within the packet.
   assign dataMis = (s_data != beatIdx);
   assign lenMis  = (lenQ != '0) &
                    (s_last ? (beatIdx != lenQ - DataWidth'(1))
                            : (beatIdx == lenQ - DataWidth'(1)));
   assign anyErr  = beat & (dataMis | lenMis);
   assign pktGood = beat & s_last & ~(pktBad | dataMis | lenMis);

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (!clear && enable) stateNext = RECV;
         RECV: begin
            if (!clear) begin
               if (StopOnErr && anyErr)                      stateNext = HALT;
               else if (beat && s_last && !enable)           stateNext = IDLE;
               else if (!beat && !enable && beatIdx == '0)   stateNext = IDLE;
            end
         end
         HALT: if (clear) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         maskIdx  <= '0;
         lenQ     <= '0;
         beatIdx  <= '0;
         pktBad   <= 1'b0;
         data_err <= 1'b0;
         len_err  <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         state    <= stateNext;
         pkt_done <= beat & s_last;
         if (state == RECV) maskIdx <= maskIdx + 3'd1;
         if (state == IDLE && stateNext == RECV) lenQ <= expected_len;
         if (clear) begin
            beatIdx  <= '0;
            pktBad   <= 1'b0;
            data_err <= 1'b0;
            len_err  <= 1'b0;
         end else if (beat) begin
            if (dataMis) data_err <= 1'b1;
            if (lenMis)  len_err  <= 1'b1;
            if (s_last) begin
               beatIdx <= '0;
               pktBad  <= 1'b0;
            end else begin
               beatIdx <= beatIdx + DataWidth'(1);
               pktBad  <= pktBad | dataMis | lenMis;
            end
         end
      end
   end

   axis_sat_counter #(.Width(CntWidth)) uPktCnt (
      .clk(clk), .reset_n(reset_n), .clear(clear), .inc(pktGood), .count(pkt_count)
   );

   axis_sat_counter #(.Width(CntWidth)) uErrCnt (
      .clk(clk), .reset_n(reset_n), .clear(clear), .inc(anyErr), .count(err_count)
   );

`ifdef AXIS_STREAM_CHECKER_STATS_EN
   logic stall;
   assign stall = busy & s_valid & ~s_ready;

   axis_sat_counter #(.Width(CntWidth)) uBeatCnt (
      .clk(clk), .reset_n(reset_n), .clear(clear), .inc(beat), .count(beat_count)
   );

   axis_sat_counter #(.Width(CntWidth)) uStallCnt (
      .clk(clk), .reset_n(reset_n), .clear(clear), .inc(stall), .count(stall_count)
   );
`endif

endmodule

// File: tb/tb_axis_stream_checker.sv
// Randomised and directed bench for axis_stream_checker against a behavioural packet model.
module tb_axis_stream_checker;

   localparam int DW  = 32;
   localparam int CW  = 6;
   localparam int MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic          reset_n = 1'b1;
   logic          enable = 1'b0, clear = 1'b0, s_valid = 1'b0, s_last = 1'b0;
   logic [DW-1:0] expected_len = '0, s_data = '0;
   logic [7:0]    ready_mask = '0;
   logic          s_ready, data_err, len_err, pkt_done, busy;
   logic [CW-1:0] pkt_count, err_count;

   logic          bEn = 1'b0, bClear = 1'b0, bValid = 1'b0, bLast = 1'b0;
   logic [DW-1:0] bLen = '0, bData = '0;
   logic [7:0]    bMask = '0;
   logic          bReady, bDataErr, bLenErr, bDone, bBusy;
   logic [15:0]   bPkt, bErr;

`ifdef AXIS_STREAM_CHECKER_STATS_EN
   logic [CW-1:0] beat_count, stall_count;
   logic [15:0]   bBeats, bStalls;
`endif

   axis_stream_checker #(.DataWidth(DW), .CntWidth(CW), .StopOnErr(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
      .expected_len(expected_len), .ready_mask(ready_mask),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .pkt_count(pkt_count), .err_count(err_count), .data_err(data_err),
      .len_err(len_err), .pkt_done(pkt_done), .busy(busy)
`ifdef AXIS_STREAM_CHECKER_STATS_EN
      , .beat_count(beat_count), .stall_count(stall_count)
`endif
   );

   axis_stream_checker #(.DataWidth(DW), .CntWidth(16), .StopOnErr(1'b1)) dutHalt (
      .clk(clk), .reset_n(reset_n), .enable(bEn), .clear(bClear),
      .expected_len(bLen), .ready_mask(bMask),
      .s_data(bData), .s_valid(bValid), .s_ready(bReady), .s_last(bLast),
      .pkt_count(bPkt), .err_count(bErr), .data_err(bDataErr),
      .len_err(bLenErr), .pkt_done(bDone), .busy(bBusy)
`ifdef AXIS_STREAM_CHECKER_STATS_EN
      , .beat_count(bBeats), .stall_count(bStalls)
`endif
   );

   int checks = 0, errors = 0;
   bit chkOn = 1'b0;
   int doneSeen = 0, stallSeen = 0;

   // Behavioural model: 0 = idle, 1 = receiving, 2 = halted (unused for StopOnErr=0).
   int            mSt, mIdx, mBeat, mPkt, mErr, mBeats, mStalls;
   bit            mBad, mDataErr, mLenErr, mDone, mAcc;
   logic [DW-1:0] mLen;

   function automatic int satInc(input int v);
      return (v >= MAX) ? v : v + 1;
   endfunction

   function automatic bit mReady();
      return (mSt == 1) && ready_mask[mIdx];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mSt = 0; mIdx = 0; mBeat = 0; mPkt = 0; mErr = 0; mBeats = 0; mStalls = 0;
      mBad = 0; mDataErr = 0; mLenErr = 0; mDone = 0; mAcc = 0; mLen = '0;
   endtask

   // Advances the model by one clock edge using the inputs present at that edge.
   task automatic modelStep();
      bit rdy, dm, lm, recv;
      rdy  = mReady();
      recv = (mSt == 1);
      mAcc = s_valid && rdy;
      mDone = 0;
      if (recv) mIdx = (mIdx + 1) % 8;
      if (clear) begin
         mPkt = 0; mErr = 0; mDataErr = 0; mLenErr = 0; mBeat = 0; mBad = 0;
         mBeats = 0; mStalls = 0;
         if (mSt == 2) mSt = 0;
      end else if (mSt == 0) begin
         if (enable) begin
            mLen = expected_len;
            mSt  = 1;
         end
      end else if (recv) begin
         if (s_valid && !rdy) mStalls = satInc(mStalls);
         if (mAcc) begin
            mBeats = satInc(mBeats);
            dm = (s_data != 32'(mBeat));
            // Length error whenever the last flag disagrees with the expected final beat.
            lm = (mLen != 0) && (s_last != (32'(mBeat) == mLen - 1));
            if (dm) mDataErr = 1;
            if (lm) mLenErr = 1;
            if (dm || lm) mErr = satInc(mErr);
            if (s_last) begin
               mDone = 1;
               if (!(mBad || dm || lm)) mPkt = satInc(mPkt);
               mBeat = 0;
               mBad  = 0;
               if (!enable) mSt = 0;
            end else begin
               mBeat++;
               mBad = mBad || dm || lm;
            end
         end else if (!enable && mBeat == 0) begin
            mSt = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chkOn) begin
         check("s_ready", s_ready, mReady());
         check("busy", busy, mSt == 1);
         check("pkt_count", pkt_count, mPkt);
         check("err_count", err_count, mErr);
         check("data_err", data_err, mDataErr);
         check("len_err", len_err, mLenErr);
         check("pkt_done", pkt_done, mDone);
`ifdef AXIS_STREAM_CHECKER_STATS_EN
         check("beat_count", beat_count, mBeats);
         check("stall_count", stall_count, mStalls);
`endif
         if (pkt_done) doneSeen++;
         if (busy && s_valid && !s_ready) stallSeen++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (reset_n) modelStep();
   endtask

   task automatic idle(input int n);
      s_valid = 0;
      s_last  = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic doClear();
      s_valid = 0;
      s_last  = 0;
      clear   = 1;
      tick();
      clear   = 0;
   endtask

   task automatic restart(input logic [DW-1:0] len);
      enable = 0;
      idle(2);
      expected_len = len;
      enable = 1;
   endtask

   task automatic sendPacket(input int n, input int badIdx, input logic [DW-1:0] badVal,
                             input int gapPct, input bit dropEn);
      for (int i = 0; i < n; i++) begin
         int w;
         while (gapPct > 0 && $urandom_range(99, 0) < gapPct) begin
            s_valid = 0;
            s_last  = 0;
            tick();
         end
         s_valid = 1;
         s_data  = (i == badIdx) ? badVal : 32'(i);
         s_last  = (i == n - 1);
         w = 0;
         do begin
            tick();
            w++;
         end while (!mAcc && w < 64);
         if (!mAcc) begin
            checks++;
            errors++;
            $display("FAIL handshake timeout: beat %0d not accepted after %0d cycles, expected accept", i, w);
            s_valid = 0;
            s_last  = 0;
            return;
         end
         if (dropEn && i == n / 2) enable = 0;
      end
      s_valid = 0;
      s_last  = 0;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      modelReset();
      #1 reset_n = 0;
      chkOn = 1;
      repeat (3) tick();
      check("reset pkt_count", pkt_count, 0);
      check("reset err_count", err_count, 0);
      check("reset s_ready", s_ready, 0);
      check("reset busy", busy, 0);
      reset_n = 1;

      // Two clean packets with full-rate ready.
      ready_mask = 8'hFF;
      expected_len = 16;
      enable = 1;
      doneSeen = 0; stallSeen = 0;
      sendPacket(16, -1, '0, 0, 0);
      sendPacket(16, -1, '0, 0, 0);
      idle(2);
      check("p1 pkt_count", pkt_count, 2);
      check("p1 err_count", err_count, 0);
      check("p1 pkt_done pulses", doneSeen, 2);
      check("p1 stall cycles", stallSeen, 0);

      // Alternating backpressure.
      doClear();
      ready_mask = 8'b0101_0101;
      stallSeen = 0;
      sendPacket(16, -1, '0, 0, 0);
      sendPacket(16, -1, '0, 0, 0);
      idle(2);
      check("p2 pkt_count", pkt_count, 2);
      check("p2 err_count", err_count, 0);
      check("p2 stalls seen", stallSeen > 0, 1);
`ifdef AXIS_STREAM_CHECKER_STATS_EN
      check("p2 beat_count", beat_count, 32);
      check("p2 stall_count nonzero", stall_count > 0, 1);
`endif

      // Corrupted beat 5, then a clean packet.
      doClear();
      ready_mask = 8'hFF;
      sendPacket(16, 5, 32'hDEAD, 0, 0);
      idle(2);
      check("p3 data_err", data_err, 1);
      check("p3 err_count", err_count, 1);
      check("p3 pkt_count", pkt_count, 0);
      sendPacket(16, -1, '0, 0, 0);
      idle(2);
      check("p3 pkt_count after clean", pkt_count, 1);

      // Early last on beat 11, then a clean packet.
      doClear();
      sendPacket(12, -1, '0, 0, 0);
      idle(2);
      check("p4 len_err", len_err, 1);
      check("p4 err_count", err_count, 1);
      check("p4 data_err", data_err, 0);
      sendPacket(16, -1, '0, 0, 0);
      idle(2);
      check("p4 pkt_count", pkt_count, 1);
      check("p4 err_count after clean", err_count, 1);

      // Asynchronous reset in the middle of a packet.
      s_valid = 1;
      for (int i = 0; i < 7; i++) begin
         s_data = 32'(i);
         tick();
      end
      #1 reset_n = 0;
      modelReset();
      s_valid = 0;
      #1;
      check("mid-reset pkt_count", pkt_count, 0);
      check("mid-reset err_count", err_count, 0);
      check("mid-reset len_err", len_err, 0);
      check("mid-reset busy", busy, 0);
      #2 reset_n = 1;
      sendPacket(16, -1, '0, 0, 0);
      idle(2);
      check("post-reset pkt_count", pkt_count, 1);
      check("post-reset err_count", err_count, 0);

      // Counter saturation with short packets.
      doClear();
      restart(2);
      for (int p = 0; p < MAX + 2; p++) sendPacket(2, 0, 32'd7, 0, 0);
      idle(2);
      check("sat err_count", err_count, MAX);
      check("sat pkt_count zero", pkt_count, 0);
      for (int p = 0; p < MAX + 1; p++) sendPacket(2, -1, '0, 0, 0);
      idle(2);
      check("sat pkt_count", pkt_count, MAX);

      // Randomised traffic.
      for (int p = 0; p < 60; p++) begin
         int n, bad;
         bit drop;
         if ($urandom_range(7, 0) == 0) doClear();
         if (!enable || $urandom_range(3, 0) == 0) begin
            ready_mask = 8'($urandom) | (8'd1 << $urandom_range(7, 0));
            restart(($urandom_range(3, 0) == 0) ? 32'd0 : 32'($urandom_range(20, 1)));
         end
         n    = (mLen != 0 && $urandom_range(3, 0) != 0) ? int'(mLen) : $urandom_range(20, 1);
         bad  = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
         drop = (n >= 4) && ($urandom_range(4, 0) == 0);
         sendPacket(n, bad, 32'($urandom_range(500, 100)), 20, drop);
         if ($urandom_range(1, 0) == 0) idle($urandom_range(3, 1));
      end
      idle(3);

      // Halt-on-error instance.
      bMask = 8'hFF;
      bLen  = 4;
      bEn   = 1;
      tick();
      bValid = 1;
      bData = 0; tick();
      bData = 1; tick();
      bData = 9; tick();
      check("halt data_err", bDataErr, 1);
      check("halt err_count", bErr, 1);
      check("halt busy", bBusy, 0);
      check("halt s_ready", bReady, 0);
      bData = 2;
      tick(); tick();
      check("halt s_ready held", bReady, 0);
      check("halt err_count held", bErr, 1);
      bValid = 0;
      bEn = 0;
      bClear = 1;
      tick();
      bClear = 0;
      check("halt clear err_count", bErr, 0);
      check("halt clear data_err", bDataErr, 0);
      check("halt clear busy", bBusy, 0);
      bEn = 1;
      tick();
      check("halt resume busy", bBusy, 1);
      for (int i = 0; i < 4; i++) begin
         bValid = 1;
         bData  = 32'(i);
         bLast  = (i == 3);
         tick();
      end
      bValid = 0;
      bLast  = 0;
      check("halt resume pkt_done", bDone, 1);
      tick();
      check("halt resume pkt_count", bPkt, 1);
      check("halt resume err_count", bErr, 0);

      chkOn = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
